cla4_serial_adder: RTL and testbench
====================================

# cla4_serial_adder

Multi-nibble serial adder that reuses one 4-bit carry-lookahead slice over several cycles. A 1-bit carry flip-flop holds the carry between nibbles, so the block feeds and consumes the carry DFF stage directly. The block accepts a pair of wide operands on a start pulse and adds them nibble by nibble, least-significant nibble first. When the last nibble completes it presents the registered sum and carry-out with a one-cycle done pulse.

## Interface
Parameters:
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE or DONE.
- a  input  W  operand A; captured on the accepting edge.
- b  input  W  operand B; captured on the accepting edge.
- cin  input  1  carry-in to nibble 0; captured on the accepting edge.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse; sum and cout are valid for the new result.
- sum  output  W  registered result.
- cout  output  1  carry out of the top nibble.
- ovf  output  1  signed overflow; present only with CLA_SERIAL_OVF_EN.

## Operation
- States: IDLE, BUSY, DONE. The state encoding is internal.
- Accepting edge:
  - Occurs in IDLE or DONE with start=1.
  - Loads a, b, cin into internal registers and clears the nibble index to 0.
  - Moves the state to BUSY.
- BUSY, each edge:
  - Combinational 4-bit CLA adds a[4i+3:4i] + b[4i+3:4i] + carry_q.
  - The result nibble goes into the internal shift/accumulate register.
  - carry_q takes the slice carry-out and the index increments.
- BUSY, completing edge (index == NIBBLES-1):
  - Copies the internal result into sum.
  - Loads cout with the final slice carry-out.
  - Moves the state to DONE.
- DONE lasts exactly one cycle:
  - With start=1: accept (back-to-back) and move to BUSY.
  - Otherwise: move to IDLE.
- start in BUSY is ignored and not queued.
- Operand inputs are not sampled after the accepting edge; they may change freely.
- Arithmetic is unsigned modulo 2^W; {cout,sum} equals a+b+cin exactly.
- NIBBLES=1 degenerates to one BUSY cycle; it is legal and required to work.

## Timing
- Reset values:
  - State IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal carry and index are 0.
- Outputs are registered.
  - busy = (state==BUSY).
  - done = (state==DONE).
- Let the accepting edge be edge 0:
  - busy is high after edges 0..NIBBLES-1.
  - The completing edge is edge NIBBLES.
  - done is high for the cycle after edge NIBBLES only.
- Latency from start sampled to done high is NIBBLES+1 edges.
- Back-to-back throughput is one result per NIBBLES+1 cycles.
- sum, cout and ovf change only on completing edges (or reset). They hold their value through IDLE and through the next operation until it completes.
- Reset mid-operation: on the next edge with rst=1 the block returns to the reset values. The pending result is discarded and no done is produced.
- rst and start on the same edge: rst wins and start is lost.

## Configuration
- Macro: CLA_SERIAL_OVF_EN.
- Defined:
  - The ovf port exists.
  - On the completing edge ovf is loaded with carry-into-MSB XOR carry-out-of-MSB of the top nibble (two's-complement overflow).
  - It holds with the same rules as sum.
- Undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use NIBBLES=4 (W=16).
- Basic add: start with a=0x1234, b=0x4321, cin=0. Response: busy high for 4 cycles, done at edge 5, sum=0x5555, cout=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0. Response: sum=0x0000, cout=1; carry must propagate through all 4 nibbles via the carry flip-flop.
- Carry-in only: a=0xFFFF, b=0x0000, cin=1. Response: sum=0x0000, cout=1. Back-to-back: hold start high in DONE with a=0x0002, b=0x0003. Response: second done exactly 5 cycles later, sum=0x0005.
- Busy protection: pulse start in the 2nd BUSY cycle with a=0x1111 during an operation on 0x1000+0x0001. Response: single done, sum=0x1001, no extra BUSY period.
- Reset mid-operation: assert rst for one cycle at the 2nd BUSY cycle of 0xAAAA+0x5555. Response:
  - Next cycle: busy=0, sum=0, cout=0.
  - done never pulses.
  - A subsequent 0x0001+0x0001 gives sum=0x0002.
- Overflow (macro defined): a=0x7FFF, b=0x0001. Response: sum=0x8000, ovf=1, cout=0. Then a=0xFFFF, b=0x0001. Response: ovf=0, cout=1.

Source files
------------

// File: rtl/cla4_serial_adder.sv
// Serial multi-nibble adder: one 4-bit carry-lookahead slice reused over NIBBLES cycles.
// Optional macro CLA_SERIAL_OVF_EN adds the registered signed-overflow output ovf.
module cla4_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
`ifdef CLA_SERIAL_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    acc;
    logic            carry_q;
    logic [IW-1:0]   idx;

    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      g;
    logic [3:0]      p;
    logic [4:0]      c;
    logic [3:0]      s_nib;
    logic [W-1:0]    result;
    logic            last;

    // Carry-lookahead slice on the current nibble, plus the accumulator with it merged in
    always_comb begin
        a_nib  = a_q[{idx, 2'b00} +: 4];
        b_nib  = b_q[{idx, 2'b00} +: 4];
        g      = a_nib & b_nib;
        p      = a_nib ^ b_nib;
        c[0]   = carry_q;
        c[1]   = g[0] | (p[0] & c[0]);
        c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
        c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s_nib  = p ^ c[3:0];
        result = acc;
        result[{idx, 2'b00} +: 4] = s_nib;
        last   = (idx == IW'(NIBBLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx     <= '0;
                        state   <= BUSY;
                        busy    <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                BUSY: begin
                    acc     <= result;
                    carry_q <= c[4];
                    idx     <= idx + IW'(1);
                    // Top nibble: publish the result; outputs hold until the next completion
                    if (last) begin
                        sum   <= result;
                        cout  <= c[4];
`ifdef CLA_SERIAL_OVF_EN
                        ovf   <= c[3] ^ c[4];
`endif
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla4_serial_adder.sv
// Self-checking bench for cla4_serial_adder (NIBBLES=4): directed scenarios plus random adds
// compared against a plain-arithmetic reference model.
module tb_cla4_serial_adder;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
`ifdef CLA_SERIAL_OVF_EN
    logic          ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  exp_sum  = '0;
    logic          exp_cout = 1'b0;
    logic          exp_ovf  = 1'b0;

    cla4_serial_adder #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef CLA_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: plain wide addition; overflow from operand/result signs
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        logic [W:0] full;
        full     = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        exp_ovf  = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sum"},  32'(sum),  32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef CLA_SERIAL_OVF_EN
        check({tag, "_ovf"},  32'(ovf),  32'(exp_ovf));
`endif
    endtask

    // Called at a negedge: issue one add, scramble inputs while busy, check timing and result
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc);
        logic [W-1:0] old_sum;
        logic         old_cout;
        old_sum  = exp_sum;
        old_cout = exp_cout;
        start = 1'b1; a = ta; b = tb_v; cin = tc;
        @(posedge clk);
        #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int i = 0; i < int'(N); i++) begin
            @(negedge clk);
            check({tag, "_busy_hi"}, 32'(busy), 32'd1);
            check({tag, "_done_lo"}, 32'(done), 32'd0);
            if (i == int'(N) - 1) begin
                check({tag, "_sum_hold"},  32'(sum),  32'(old_sum));
                check({tag, "_cout_hold"}, 32'(cout), 32'(old_cout));
            end
            @(posedge clk);
        end
        model(ta, tb_v, tc);
        @(negedge clk);
        check_result(tag);
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef CLA_SERIAL_OVF_EN
        check("rst_ovf",  32'(ovf),  32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op("basic", 16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sum_hold", 32'(sum), 32'h5555);

        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        run_op("cin_only", 16'hFFFF, 16'h0000, 1'b1);
        // Back-to-back: start issued in the DONE cycle
        run_op("b2b", 16'h0002, 16'h0003, 1'b0);
        check("b2b_sum_const", 32'(sum), 32'h0005);

        // start during BUSY must be ignored
        @(negedge clk);
        start = 1'b1; a = 16'h1000; b = 16'h0001; cin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 16'h1111;
        @(posedge clk);
        #1 start = 1'b0;
        model(16'h1000, 16'h0001, 1'b0);
        @(negedge clk);
        check("prot_busy3", 32'(busy), 32'd1);
        check("prot_done3", 32'(done), 32'd0);
        @(negedge clk);
        check("prot_busy4", 32'(busy), 32'd1);
        @(negedge clk);
        check_result("prot");
        check("prot_sum_const", 32'(sum), 32'h1001);
        @(negedge clk);
        check("prot_no_extra_busy", 32'(busy), 32'd0);
        check("prot_single_done",   32'(done), 32'd0);

        // Reset in the second BUSY cycle discards the operation
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_sum",  32'(sum),  32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("mid_rst_no_done", 32'(done_seen), 32'd0);
        run_op("after_rst", 16'h0001, 16'h0001, 1'b0);
        check("after_rst_sum_const", 32'(sum), 32'h0002);

        @(negedge clk);
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
        @(negedge clk);
        run_op("ovf_wrap", 16'hFFFF, 16'h0001, 1'b0);

        // Random adds, mixing idle gaps with back-to-back issue
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom));
        end

        @(negedge clk);
        check("end_idle", 32'(busy), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
